// File: rtl/mul_pkg.sv
// Shared types, widths and helpers for the iterative shift-add multiplier.
package mul_pkg;

  localparam int MUL_SIZE = 16;
  localparam int PRD_W    = MUL_SIZE * 5 / 2;
  localparam int ACC_W    = 2 * MUL_SIZE;
  localparam int CNT_W    = $clog2(MUL_SIZE + 1);
  localparam int MAG_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } mul_state_t;

  // Two's-complement magnitude when neg is set; the most negative value
  // comes back as its unsigned bit pattern once the caller truncates.
  function automatic logic [MAG_W-1:0] cond_mag(input logic [MAG_W-1:0] v,
                                                input logic neg);
    return neg ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: sign/magnitude operands, one multiplier bit
// per cycle, fractional shift and sign restore on the way out.
//
// state    | meaning
// S_IDLE   | waiting for start; out holds last product
// S_CALC   | SIZE add/shift iterations, LSB of multiplier first
// S_FINISH | format product, pulse done, return to idle
module mul_iter
  import mul_pkg::*;
#(
  parameter int SIZE = MUL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE-1:0]       x_in,
  input  logic [SIZE-1:0]       y_in,
  input  logic                  ps_mul_xSgn,
  input  logic                  ps_mul_ySgn,
  input  logic                  ps_mul_IbF,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*5/2-1:0]   out
);

  localparam int PW = SIZE * 5 / 2;
  localparam int AW = 2 * SIZE;
  localparam int CW = $clog2(SIZE + 1);

  mul_state_t      state, state_nxt;

  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [SIZE-1:0] mplier;
  logic [CW-1:0]   count;
  logic            neg;
  logic            ibf;

  logic            x_neg, y_neg;
  logic [MAG_W-1:0] x_mag_w, y_mag_w;
  logic            unused_mag_hi;
  logic            last_iter;
  logic [PW-1:0]   prod_abs, prod_shf, prod;

  assign busy      = (state != S_IDLE);
  assign last_iter = (count == CW'(SIZE - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CALC;
      S_CALC:   if (last_iter) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    x_neg    = ps_mul_xSgn & x_in[SIZE-1];
    y_neg    = ps_mul_ySgn & y_in[SIZE-1];
    x_mag_w  = cond_mag(MAG_W'(x_in), x_neg);
    y_mag_w  = cond_mag(MAG_W'(y_in), y_neg);
    unused_mag_hi = ^{x_mag_w[MAG_W-1:SIZE], y_mag_w[MAG_W-1:SIZE]};
    // Guard bits absorb the fractional shift of -1.0 * -1.0 without saturating.
    prod_abs = PW'(acc);
    prod_shf = ibf ? (prod_abs << 1) : prod_abs;
    prod     = neg ? (-prod_shf) : prod_shf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      ibf    <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= AW'(x_mag_w[SIZE-1:0]);
            mplier <= y_mag_w[SIZE-1:0];
            acc    <= '0;
            count  <= '0;
            neg    <= x_neg ^ y_neg;
            ibf    <= ps_mul_IbF;
          end
        end
        S_CALC: begin
          // mcand is pre-shifted each cycle, so it always equals x_mag << count.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        S_FINISH: begin
          out  <= prod;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed corner cases plus random
// operands checked against a plain-arithmetic product model.
module tb_mul_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        ps_mul_xSgn;
  logic        ps_mul_ySgn;
  logic        ps_mul_IbF;
  logic        busy;
  logic        done;
  logic [39:0] out;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_out;

  mul_iter #(.SIZE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .x_in        (x_in),
    .y_in        (y_in),
    .ps_mul_xSgn (ps_mul_xSgn),
    .ps_mul_ySgn (ps_mul_ySgn),
    .ps_mul_IbF  (ps_mul_IbF),
    .busy        (busy),
    .done        (done),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic xs, input logic ys, input logic f);
    longint a, b, p;
    a = xs ? longint'($signed(x)) : longint'(x);
    b = ys ? longint'($signed(y)) : longint'(y);
    p = a * b;
    if (f) p = p * 2;
    return p[39:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present operands with start for one edge; busy must rise, done must be low.
  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic xs, input logic ys, input logic f);
    x_in = x; y_in = y; ps_mul_xSgn = xs; ps_mul_ySgn = ys; ps_mul_IbF = f;
    start = 1'b1;
    exp_out = model(x, y, xs, ys, f);
    @(posedge clk); #1;
    start = 1'b0;
    x_in = 16'($urandom); y_in = 16'($urandom);
    ps_mul_xSgn = 1'($urandom); ps_mul_ySgn = 1'($urandom); ps_mul_IbF = 1'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_low_after_start", 64'(done), 64'd0);
  endtask

  // Wait for done, optionally pulsing a spurious start at edge inj.
  task automatic wait_done(input string tag, input int inj);
    int lat;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == inj) begin
        start = 1'b1; x_in = 16'h7777; y_in = 16'h1234;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd17);
    chk({tag, "_out"}, 64'(out), 64'(exp_out));
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  // One idle cycle after done: pulse ended, product held.
  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_out_held"}, 64'(out), 64'(exp_out));
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b1;
    x_in = 16'h1111; y_in = 16'h2222;
    ps_mul_xSgn = 1'b0; ps_mul_ySgn = 1'b0; ps_mul_IbF = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);

    issue(16'hFFFD, 16'h0005, 1'b1, 1'b1, 1'b0);
    chk("model_neg15", 64'(exp_out), 64'h00FF_FFFF_FFF1);
    wait_done("sint", 0);
    idle_check("sint");

    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    wait_done("uns_max", 0);
    chk("uns_max_const", 64'(out), 64'h0000_FFFE_0001);
    idle_check("uns_max");

    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    wait_done("mixed", 0);
    chk("mixed_const", 64'(out), 64'h00FF_FFFF_0001);
    idle_check("mixed");

    issue(16'h4000, 16'h4000, 1'b1, 1'b1, 1'b1);
    wait_done("frac_half", 0);
    chk("frac_half_const", 64'(out), 64'h0000_2000_0000);

    // Back-to-back: start asserted in the same cycle as done.
    issue(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1);
    wait_done("frac_m1", 0);
    chk("frac_m1_const", 64'(out), 64'h0000_8000_0000);

    issue(16'h0101, 16'hFF00, 1'b0, 1'b1, 1'b0);
    wait_done("ignored_start", 5);
    idle_check("ignored_start");
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ignored_start_no_extra_done", 64'(dones), 64'd0);

    // Abort mid-operation with reset.
    issue(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    dones = 0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_out_cleared", 64'(out), 64'd0);
    issue(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
    wait_done("after_abort", 0);
    chk("after_abort_const", 64'(out), 64'h0000_0000_0006);
    idle_check("after_abort");

    for (int i = 0; i < 12; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      wait_done("rand", 0);
      if (i % 3 != 0) idle_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
